// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped machine timer: register offsets,
// CTRL bit positions and reset values.
package timer_pkg;

  localparam logic [4:0] MTIME_LO_OFS    = 5'h00;
  localparam logic [4:0] MTIME_HI_OFS    = 5'h04;
  localparam logic [4:0] MTIMECMP_LO_OFS = 5'h08;
  localparam logic [4:0] MTIMECMP_HI_OFS = 5'h0C;
  localparam logic [4:0] CTRL_OFS        = 5'h10;
  localparam logic [4:0] PRESCALE_OFS    = 5'h14;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Offset of the 32-bit half 'half' (0 = LO, 1 = HI) of a 64-bit register pair.
  function automatic logic [4:0] half_ofs(input logic [4:0] lo_ofs, input int half);
    return lo_ofs + (half != 0 ? 5'h04 : 5'h00);
  endfunction

endpackage

// File: rtl/mtimer_unit_if.sv
// Data-memory side bus between the MEM stage and the machine timer.
interface mtimer_unit_if;

  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        sel;

  modport master (
    output addr, rd_en, wr_en, wdata,
    input  rdata, rvalid, sel
  );

  modport slave (
    input  addr, rd_en, wr_en, wdata,
    output rdata, rvalid, sel
  );

endinterface

// File: rtl/mtimer_unit_tick_gen.sv
// Programmable prescaler: emits one tick every (div+1) enabled cycles.
module tick_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  div_wr,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count_reg;
  logic [PRESCALE_W-1:0] count_next;

  always_comb begin
    tick       = en && (count_reg == div);
    count_next = count_reg + 1'b1;
    // A divider rewrite restarts the period so the new ratio applies cleanly.
    if (!en || div_wr || tick) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/mtimer_unit.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on the data bus, level interrupt
// when mtime >= mtimecmp and IE is set.
module mtimer_unit
  import timer_pkg::*;
#(
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_F000
) (
  input  logic         clk,
  input  logic         rst,
  mtimer_unit_if.slave bus,
  output logic         timer_interrupt
);

  logic [63:0]           mtime_reg, mtime_next;
  logic [63:0]           mtimecmp_reg, mtimecmp_next;
  logic                  en_reg, en_next;
  logic                  ie_reg, ie_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic [31:0]           hi_shadow_reg;
  logic [31:0]           rdata_reg;
  logic                  rvalid_reg;
  logic                  irq_reg;

  logic        in_window;
  logic        aligned;
  logic [4:0]  ofs;
  logic        rd_hit;
  logic        wr_hit;
  logic        tick;
  logic        prescale_wr;
  logic [1:0]  mtime_wr;
  logic [1:0]  mtimecmp_wr;
  logic [31:0] rd_mux;

  assign in_window = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign aligned   = (bus.addr[1:0] == 2'b00);
  assign ofs       = bus.addr[4:0];
  assign rd_hit    = bus.rd_en && in_window && aligned;
  assign wr_hit    = bus.wr_en && in_window && aligned;

  assign prescale_wr = wr_hit && (ofs == PRESCALE_OFS);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half_wr
      assign mtime_wr[gi]    = wr_hit && (ofs == half_ofs(MTIME_LO_OFS, gi));
      assign mtimecmp_wr[gi] = wr_hit && (ofs == half_ofs(MTIMECMP_LO_OFS, gi));
    end
  endgenerate

  tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (en_reg),
    .div    (prescale_reg),
    .div_wr (prescale_wr),
    .tick   (tick)
  );

  // Any software write to mtime swallows a coincident tick for the full 64 bits.
  always_comb begin
    mtime_next = mtime_reg;
    if (|mtime_wr) begin
      if (mtime_wr[0]) mtime_next[31:0]  = bus.wdata;
      if (mtime_wr[1]) mtime_next[63:32] = bus.wdata;
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_next = mtimecmp_reg;
    if (mtimecmp_wr[0]) mtimecmp_next[31:0]  = bus.wdata;
    if (mtimecmp_wr[1]) mtimecmp_next[63:32] = bus.wdata;
  end

  always_comb begin
    en_next       = en_reg;
    ie_next       = ie_reg;
    prescale_next = prescale_reg;
    if (wr_hit && (ofs == CTRL_OFS)) begin
      en_next = bus.wdata[CTRL_EN_BIT];
      ie_next = bus.wdata[CTRL_IE_BIT];
    end
    if (prescale_wr) begin
      prescale_next = bus.wdata[PRESCALE_W-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ofs)
      MTIME_LO_OFS:    rd_mux = mtime_reg[31:0];
      MTIME_HI_OFS:    rd_mux = hi_shadow_reg;
      MTIMECMP_LO_OFS: rd_mux = mtimecmp_reg[31:0];
      MTIMECMP_HI_OFS: rd_mux = mtimecmp_reg[63:32];
      CTRL_OFS: begin
        rd_mux[CTRL_EN_BIT] = en_reg;
        rd_mux[CTRL_IE_BIT] = ie_reg;
      end
      PRESCALE_OFS:    rd_mux[PRESCALE_W-1:0] = prescale_reg;
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_reg     <= '0;
      mtimecmp_reg  <= MTIMECMP_RST;
      en_reg        <= 1'b0;
      ie_reg        <= 1'b0;
      prescale_reg  <= '0;
      hi_shadow_reg <= '0;
      rdata_reg     <= '0;
      rvalid_reg    <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      en_reg       <= en_next;
      ie_reg       <= ie_next;
      prescale_reg <= prescale_next;
      rvalid_reg   <= rd_hit;
      if (rd_hit) begin
        rdata_reg <= rd_mux;
      end
      // Latching HI on a LO read lets software read a torn-free 64-bit value.
      if (rd_hit && (ofs == MTIME_LO_OFS)) begin
        hi_shadow_reg <= mtime_reg[63:32];
      end
      irq_reg <= ie_reg && (mtime_reg >= mtimecmp_reg);
    end
  end

  assign bus.rdata       = rdata_reg;
  assign bus.rvalid      = rvalid_reg;
  assign bus.sel         = in_window;
  assign timer_interrupt = irq_reg;

endmodule

// File: tb/tb_mtimer_unit.sv
// Bench for mtimer_unit: register table, prescaler/carry/shadow/interrupt
// sequences, with read data checked through a response queue.
module tb_mtimer_unit;
  import timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_F000;

  logic clk = 1'b0;
  logic rst;
  logic irq;

  always #5 clk = ~clk;

  mtimer_unit_if bus ();

  mtimer_unit #(
    .PRESCALE_W (16),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .timer_interrupt (irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_sel;
    logic        exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t sb[$];
  vec_t vt[16];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] data);
    exp_t e;
    e.tag  = tag;
    e.data = data;
    sb.push_back(e);
  endtask

  // Called at a falling edge; drives one bus cycle and returns at the next falling edge.
  task automatic op(input logic rd, input logic wr, input logic [31:0] a,
                    input logic [31:0] wd, input logic exp_rv,
                    input logic [31:0] exp, input string tag);
    #1;
    bus.addr  = a;
    bus.rd_en = rd;
    bus.wr_en = wr;
    bus.wdata = wd;
    if (exp_rv) push_exp(tag, exp);
    @(negedge clk);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic wr_reg(input logic [4:0] o, input logic [31:0] d);
    op(1'b0, 1'b1, BASE + 32'(o), d, 1'b0, 32'h0, "");
  endtask

  task automatic rd_reg(input logic [4:0] o, input logic [31:0] exp, input string tag);
    op(1'b1, 1'b0, BASE + 32'(o), 32'h0, 1'b1, exp, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 rdata=%h expected no response", bus.rdata);
      end else begin
        e = sb.pop_front();
        chk(e.tag, bus.rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr  = 32'h0;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.wdata = 32'h0;
    rst       = 1'b1;
    idle(3);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    rst = 1'b0;

    // {rd, wr, addr, wdata, exp_sel, exp_rvalid, exp_rdata}
    vt[0]  = '{1'b0, 1'b1, BASE + 32'h08, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
    vt[1]  = '{1'b1, 1'b0, BASE + 32'h08, 32'h0,         1'b1, 1'b1, 32'h1234_5678};
    vt[2]  = '{1'b1, 1'b1, BASE + 32'h0C, 32'h0000_00AB, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vt[3]  = '{1'b1, 1'b0, BASE + 32'h0C, 32'h0,         1'b1, 1'b1, 32'h0000_00AB};
    vt[4]  = '{1'b0, 1'b1, BASE + 32'h14, 32'h000A_BCDE, 1'b1, 1'b0, 32'h0};
    vt[5]  = '{1'b1, 1'b0, BASE + 32'h14, 32'h0,         1'b1, 1'b1, 32'h0000_BCDE};
    vt[6]  = '{1'b0, 1'b1, BASE + 32'h10, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 1'b0, BASE + 32'h10, 32'h0,         1'b1, 1'b1, 32'h0000_0002};
    vt[8]  = '{1'b0, 1'b1, BASE + 32'h18, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
    vt[9]  = '{1'b1, 1'b0, BASE + 32'h18, 32'h0,         1'b1, 1'b1, 32'h0};
    vt[10] = '{1'b1, 1'b0, BASE + 32'h1C, 32'h0,         1'b1, 1'b1, 32'h0};
    vt[11] = '{1'b1, 1'b0, BASE + 32'h02, 32'h0,         1'b1, 1'b0, 32'h0};
    vt[12] = '{1'b1, 1'b0, BASE + 32'h20, 32'h0,         1'b0, 1'b0, 32'h0};
    vt[13] = '{1'b1, 1'b0, BASE - 32'h04, 32'h0,         1'b0, 1'b0, 32'h0};
    vt[14] = '{1'b0, 1'b1, BASE + 32'h10, 32'h0,         1'b1, 1'b0, 32'h0};
    vt[15] = '{1'b1, 1'b0, BASE + 32'h10, 32'h0,         1'b1, 1'b1, 32'h0};

    for (int i = 0; i < 16; i++) begin
      #1;
      bus.addr  = vt[i].addr;
      bus.rd_en = vt[i].rd;
      bus.wr_en = vt[i].wr;
      bus.wdata = vt[i].wdata;
      #1;
      chk($sformatf("vec%0d_sel", i), {31'b0, bus.sel}, {31'b0, vt[i].exp_sel});
      if (vt[i].exp_rv) push_exp($sformatf("vec%0d_rdata", i), vt[i].exp_rdata);
      @(negedge clk);
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
    end

    // Prescale 0: one increment per cycle; prescale 3: one per four cycles.
    wr_reg(PRESCALE_OFS, 32'h0);
    wr_reg(CTRL_OFS, 32'h1);
    wr_reg(MTIME_LO_OFS, 32'd100);
    for (int i = 0; i < 4; i++) rd_reg(MTIME_LO_OFS, 32'd100 + 32'(i), $sformatf("div1_lo%0d", i));
    wr_reg(PRESCALE_OFS, 32'h3);
    wr_reg(MTIME_LO_OFS, 32'd200);
    begin
      logic [31:0] div4_exp [8];
      div4_exp = '{32'd200, 32'd200, 32'd200, 32'd201, 32'd201, 32'd201, 32'd201, 32'd202};
      for (int i = 0; i < 8; i++) rd_reg(MTIME_LO_OFS, div4_exp[i], $sformatf("div4_lo%0d", i));
    end

    // Carry from LO into HI, then full 64-bit wrap.
    wr_reg(CTRL_OFS, 32'h0);
    wr_reg(PRESCALE_OFS, 32'h0);
    wr_reg(MTIME_LO_OFS, 32'hFFFF_FFFF);
    wr_reg(MTIME_HI_OFS, 32'h0);
    wr_reg(CTRL_OFS, 32'h1);
    wr_reg(CTRL_OFS, 32'h0);
    rd_reg(MTIME_LO_OFS, 32'h0, "carry_lo");
    rd_reg(MTIME_HI_OFS, 32'h1, "carry_hi");
    wr_reg(MTIME_LO_OFS, 32'hFFFF_FFFF);
    wr_reg(MTIME_HI_OFS, 32'hFFFF_FFFF);
    wr_reg(CTRL_OFS, 32'h1);
    wr_reg(CTRL_OFS, 32'h0);
    rd_reg(MTIME_LO_OFS, 32'h0, "wrap_lo");
    rd_reg(MTIME_HI_OFS, 32'h0, "wrap_hi");

    // HI returns the value latched by the LO read, not the live upper word.
    wr_reg(MTIME_LO_OFS, 32'hFFFF_FFFE);
    wr_reg(MTIME_HI_OFS, 32'h0);
    wr_reg(CTRL_OFS, 32'h1);
    rd_reg(MTIME_LO_OFS, 32'hFFFF_FFFE, "shadow_lo");
    idle(9);
    rd_reg(MTIME_HI_OFS, 32'h0, "shadow_hi");
    wr_reg(CTRL_OFS, 32'h0);
    rd_reg(MTIME_LO_OFS, 32'h0000_000A, "live_lo");
    rd_reg(MTIME_HI_OFS, 32'h1, "live_hi");

    // Interrupt rises one cycle after mtime reaches mtimecmp.
    wr_reg(MTIMECMP_LO_OFS, 32'h20);
    wr_reg(MTIMECMP_HI_OFS, 32'h0);
    wr_reg(MTIME_LO_OFS, 32'h0);
    wr_reg(MTIME_HI_OFS, 32'h0);
    wr_reg(CTRL_OFS, 32'h3);
    for (int j = 0; j <= 40; j++) begin
      chk($sformatf("irq_rise_c%0d", j), {31'b0, irq}, (j >= 33) ? 32'h1 : 32'h0);
      @(negedge clk);
    end
    wr_reg(MTIMECMP_LO_OFS, 32'h1000);
    chk("irq_cmp_wr_same", {31'b0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_cmp_wr_fall", {31'b0, irq}, 32'h0);

    // IE gates the interrupt.
    wr_reg(CTRL_OFS, 32'h1);
    wr_reg(MTIMECMP_LO_OFS, 32'h10);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("irq_ie0_c%0d", j), {31'b0, irq}, 32'h0);
      @(negedge clk);
    end
    wr_reg(CTRL_OFS, 32'h3);
    chk("irq_ie_set_same", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_ie_set_rise", {31'b0, irq}, 32'h1);

    // Reset mid-run with a read in flight.
    #1;
    rst       = 1'b1;
    bus.addr  = BASE;
    bus.rd_en = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.rd_en = 1'b0;
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    chk("midrst_rvalid", {31'b0, bus.rvalid}, 32'h0);
    rd_reg(MTIME_LO_OFS, 32'h0, "midrst_mtime_lo");
    rd_reg(MTIME_HI_OFS, 32'h0, "midrst_mtime_hi");
    rd_reg(MTIMECMP_LO_OFS, 32'hFFFF_FFFF, "midrst_cmp_lo");
    rd_reg(MTIMECMP_HI_OFS, 32'hFFFF_FFFF, "midrst_cmp_hi");
    rd_reg(CTRL_OFS, 32'h0, "midrst_ctrl");
    rd_reg(PRESCALE_OFS, 32'h0, "midrst_prescale");

    // Write coinciding with a tick wins; misaligned accesses are ignored.
    wr_reg(CTRL_OFS, 32'h1);
    wr_reg(MTIME_LO_OFS, 32'h55);
    rd_reg(MTIME_LO_OFS, 32'h55, "tick_drop_lo");
    wr_reg(CTRL_OFS, 32'h0);
    op(1'b1, 1'b0, BASE + 32'h02, 32'h0, 1'b0, 32'h0, "");
    op(1'b0, 1'b1, BASE + 32'h02, 32'h1234, 1'b0, 32'h0, "");
    op(1'b0, 1'b1, BASE + 32'h11, 32'h3, 1'b0, 32'h0, "");
    rd_reg(MTIME_LO_OFS, 32'h57, "misalign_lo");
    rd_reg(CTRL_OFS, 32'h0, "misalign_ctrl");

    idle(3);
    chk("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtimer_unit.md
Name: mtimer_unit

Overview:
- Memory-mapped RISC-V machine timer. Generates the level-sensitive `timer_interrupt` consumed by the processor's CSR/trap logic in the MEM stage.
- Sits on the data-memory bus beside `data_mem`. The bus is driven by the MEM-stage address (`opr_res_mem`), store data (`rdata2_mem`) and `rd_en_mem`/`wr_en_mem`.
- Holds a 64-bit free-running `mtime` advanced by a programmable prescaler, plus a 64-bit `mtimecmp` compare register.

Parameters:
- PRESCALE_W, 16, width of the prescaler divide register and counter.
- BASE_ADDR, 32'h0000_F000, byte base address of the register window.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- addr  in  32  byte address from MEM stage
- rd_en  in  1  bus read strobe
- wr_en  in  1  bus write strobe
- wdata  in  32  store data
- rdata  out  32  read data, registered
- rvalid  out  1  rdata valid, one-cycle pulse
- sel  out  1  combinational, addr falls in the 32-byte window; external read-mux select
- timer_interrupt  out  1  machine timer interrupt request, level

Behaviour:
- Register map (byte offsets from BASE_ADDR, word accesses only):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN, bit1 IE, others read 0
  - 0x14 PRESCALE: [PRESCALE_W-1:0]
  - 0x18 and 0x1C: read 0, writes ignored.
- Address handling:
  - Access with addr[1:0]≠0 or outside the window: ignored, no rvalid.
  - Access in the window but not to a defined register: rvalid=1, rdata=0.
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=0, prescaler count=0, hi_shadow=0, rdata=0, rvalid=0, timer_interrupt=0.
- Prescaler:
  - While EN=1, count increments each cycle.
  - When count==PRESCALE: tick=1 that cycle and count returns to 0. PRESCALE=0 therefore gives a tick every cycle.
  - While EN=0: count held at 0, no ticks.
  - A write to PRESCALE resets count to 0 in the same cycle.
- mtime:
  - On each tick, mtime increments by 1 as a full 64-bit add with carry from LO into HI.
  - 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A write to MTIME_LO or MTIME_HI replaces that half. A tick in the same cycle is dropped for the whole 64-bit value: no increment that cycle.
- Read latency:
  - rd_en in cycle N gives rdata/rvalid in cycle N+1.
  - rdata holds its value until the next valid read. rvalid=0 in other cycles.
- Atomic 64-bit read: reading MTIME_LO copies the current mtime[63:32] into hi_shadow. Reading MTIME_HI returns hi_shadow, not live mtime[63:32].
- Simultaneous rd_en and wr_en to the same register: the read returns the pre-write value and the write takes effect.
- Interrupt:
  - timer_interrupt registered: next-cycle value = IE & (mtime >= mtimecmp), unsigned 64-bit compare on the current-cycle register values.
  - Latency: one cycle after the compare condition becomes true.
  - Deassertion is by software only: write a larger mtimecmp, or clear IE. Deasserts one cycle after the write.
  - No sticky pending bit.
- Reset mid-operation: all state returns to reset values in the next cycle; an in-flight read yields no rvalid.

Decomposition:
- Package `timer_pkg`:
  - Register offset localparams: MTIME_LO_OFS, MTIME_HI_OFS, MTIMECMP_LO_OFS, MTIMECMP_HI_OFS, CTRL_OFS, PRESCALE_OFS.
  - CTRL bit indices: CTRL_EN_BIT, CTRL_IE_BIT.
  - Reset constant MTIMECMP_RST.
- One sub-module, `tick_gen`, containing the prescaler counter and its interface:
  - clk, rst, en, div, div_wr → tick.
- Bus decode, registers, compare and interrupt logic stay in `mtimer_unit`.

Test Plan:
- Reset then CTRL=0x1, PRESCALE=0 → MTIME_LO reads increase by 1 per cycle; with PRESCALE=3, MTIME_LO advances once every 4 cycles.
- MTIME_LO=0xFFFF_FFFF, MTIME_HI=0, EN=1, PRESCALE=0 → after the next tick, read LO=0x0000_0000 and HI=0x0000_0001.
- mtime=0x0000_0000_FFFF_FFFE, then read LO; continue ticking and read HI 10 cycles later → HI returns shadow 0x0, not 0x1.
- mtimecmp=0x20, CTRL=0x3, PRESCALE=0, mtime=0 → timer_interrupt rises exactly one cycle after mtime reaches 0x20. Then write MTIMECMP_LO=0x1000 → interrupt falls one cycle after the write.
- mtime ≥ mtimecmp with IE=0 → timer_interrupt stays 0; setting IE=1 → rises one cycle later. Assert rst mid-run → next cycle mtime=0, timer_interrupt=0, mtimecmp=all ones.
- Write MTIME_LO=0x55 in the same cycle as a tick, plus a misaligned access (addr=BASE_ADDR+2) → MTIME_LO=0x55 with no increment; misaligned access yields no rvalid and no register change.
